gpio0_clkout: RTL
=================

Name: gpio0_clkout

Overview:
Avalon-MM slave output PIO driving a WIDTH-bit GPIO header port. It is the write-side counterpart to the existing clock-input PIO.
- Each output bit is driven either from a software-written DATA register or from an internal programmable clock generator (divided system clock), selected per bit.
- Sits on the NIOS system interconnect alongside the other PIO slaves.

Parameters:
WIDTH, 2, number of output bits on out_port (1..32)
DIV_WIDTH, 16, width of divider register and half-period counter (1..32)
RESET_VALUE, 0, reset value of DATA register (WIDTH bits)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
address  input  3  Avalon word address
chipselect  input  1  slave select, qualifies writes
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  WIDTH  registered GPIO output

Behaviour:
- Reset (reset_n=0 at rising edge): DATA=RESET_VALUE, CTRL=0, DIV=0, cnt=0, gen_clk=0, readdata=0, out_port=RESET_VALUE. Reset mid-operation aborts generation immediately; the first clock with reset_n=1 resumes normal operation.
- Write occurs at an edge when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] (or [DIV_WIDTH-1:0] for DIV) is used; upper bits are ignored.
- Register map:
  - 0 DATA: R/W.
  - 1 CTRL: R/W, gen_en[WIDTH-1:0], per-bit generator select.
  - 2 DIV: R/W, half-period minus 1.
  - 3 STATUS: RO, bit0=gen_clk, bits[DIV_WIDTH+15:16]=cnt truncated to 32 bits; writes ignored.
  - 4 OUTSET: WO, DATA <= DATA | wd.
  - 5 OUTCLEAR: WO, DATA <= DATA & ~wd.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Reads:
  - readdata <= mux(address) on every edge, independent of chipselect; read latency is 1 cycle.
  - Fields are zero-extended to 32 bits.
  - Reads of 4, 5, 6, 7 return 0.
  - Read data reflects register state before any write occurring on the same edge.
- Generator, when CTRL != 0:
  - if cnt==DIV: cnt<=0 and gen_clk<=~gen_clk; else cnt<=cnt+1.
  - Output period = 2*(DIV+1) clk cycles, 50% duty. DIV=0 gives clk/2. DIV=all-ones is the maximum period; cnt never exceeds DIV.
- Generator idle, when CTRL==0: cnt<=0, gen_clk<=0 every cycle. Therefore a 0 -> nonzero CTRL write starts with gen_clk=0, and the first rising edge of gen_clk occurs DIV+1 cycles after the CTRL write edge.
- Write to DIV: cnt<=0 on the same edge, gen_clk unchanged; the new half-period applies from that edge. This avoids overrun when the new DIV is smaller than cnt.
- Output mux: out_port <= (DATA & ~CTRL) | ({WIDTH{gen_clk}} & CTRL), registered. A register write at edge N is visible on out_port at edge N+1.
- Bits with CTRL=0 hold DATA and are glitch-free. Clearing a CTRL bit returns that bit to DATA at the next edge.
- Writing DATA while the corresponding CTRL bit is set updates DATA only; the value appears on out_port when that CTRL bit is cleared.

Test Plan:
1. Reset with RESET_VALUE=2'b10, then release -> out_port=2'b10, and reads of 0/1/2/3 return 0x2/0/0/0 one cycle after address is applied.
2. Write DATA=0x3 at edge N -> out_port=2'b11 at N+1. OUTCLEAR 0x1 -> DATA=0x2. OUTSET 0x1 -> DATA=0x3. Write DATA=0xFFFFFFFC -> readback 0x0.
3. DIV=0, CTRL=0x1 -> out_port[0] toggles every cycle (period 2) and out_port[1] holds DATA. DIV=4 -> period 10 cycles, high for 5.
4. CTRL=0x3 running with DIV=9: write DIV=2 when cnt=7 -> cnt=0 on that edge, and the next toggle comes 3 cycles later with no overrun or wrap.
5. CTRL cleared mid-high phase -> out_port returns to DATA next cycle, and STATUS reads gen_clk=0, cnt=0. Assert reset_n=0 while running -> all outputs at reset values on that edge.
6. chipselect=0 with write_n=0 to DATA -> no change. Write to address 3, 6 or 7 -> no register change. Read of 6 -> 0x0.

Source files
------------

// File: rtl/gpio0_clkout.sv
// Avalon-MM output PIO: each GPIO bit is driven either by the DATA register
// or by a programmable divided-clock generator, chosen per bit in CTRL.
module gpio0_clkout #(
  parameter int unsigned      WIDTH       = 2,
  parameter int unsigned      DIV_WIDTH   = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_DIV    = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_ctrl;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_gen_clk;

  logic                 w_wr;
  logic                 w_div_wr;
  logic [31:0]          w_status;
  logic [31:0]          w_rd_mux;
  logic                 w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_div_wr    = w_wr && (address == ADDR_DIV);
  assign w_unused_wd = ^writedata;

  // cnt lives at bit 16 upward; anything beyond bit 31 is dropped.
  assign w_status = 32'({r_cnt, 15'd0, r_gen_clk});

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:   w_rd_mux = 32'(r_data);
      ADDR_CTRL:   w_rd_mux = 32'(r_ctrl);
      ADDR_DIV:    w_rd_mux = 32'(r_div);
      ADDR_STATUS: w_rd_mux = w_status;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data    <= RESET_VALUE;
      r_ctrl    <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_gen_clk <= 1'b0;
      readdata  <= '0;
      out_port  <= RESET_VALUE;
    end else begin
      readdata <= w_rd_mux;
      out_port <= (r_data & ~r_ctrl) | ({WIDTH{r_gen_clk}} & r_ctrl);

      // A DIV write restarts the half-period so a smaller DIV can never be overrun.
      if (r_ctrl == '0) begin
        r_cnt     <= '0;
        r_gen_clk <= 1'b0;
      end else if (w_div_wr) begin
        r_cnt <= '0;
      end else if (r_cnt == r_div) begin
        r_cnt     <= '0;
        r_gen_clk <= ~r_gen_clk;
      end else begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end

      if (w_wr) begin
        case (address)
          ADDR_DATA:   r_data <= writedata[WIDTH-1:0];
          ADDR_CTRL:   r_ctrl <= writedata[WIDTH-1:0];
          ADDR_DIV:    r_div  <= writedata[DIV_WIDTH-1:0];
          ADDR_OUTSET: r_data <= r_data | writedata[WIDTH-1:0];
          ADDR_OUTCLR: r_data <= r_data & ~writedata[WIDTH-1:0];
          default:     ;
        endcase
      end
    end
  end

endmodule
